// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer of an async FIFO (rclk domain).
// Issues FIFO reads against rempty and absorbs the FIFO's one-cycle registered read
// latency. Words are staged in a small circular output queue and presented as a
// valid/ready stream with out_last every PKT_LEN words. The read request uses only
// registered occupancy, so out_ready has no combinational path to the FIFO.
// OBUF_DEPTH must be >= 2 (3 or more sustains one word per cycle). PKT_LEN must be >= 1.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 9,
  parameter int OBUF_DEPTH = 3,
  parameter int PKT_LEN    = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  drain_en,
  input  logic                  fifo_rempty,
  input  logic [DATA_WIDTH-1:0] fifo_data_read,
  output logic                  fifo_read_enable,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  obuf_ovf
);

  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  localparam logic [PW-1:0] PTR_LAST  = PW'(OBUF_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(OBUF_DEPTH);
  localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(OBUF_DEPTH);
  localparam logic [BW-1:0] BEAT_LAST = BW'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] r_mem [OBUF_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_cnt;
  logic                  r_rd_pend;
  logic [BW-1:0]         r_beat;
  logic [CNT_WIDTH-1:0]  r_word_cnt;
  logic                  r_ovf;

  logic [CW:0]           w_occ;
  logic                  w_rd_en;
  logic                  w_rd_fire;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_full;
  logic                  w_wr_ok;
  logic                  w_ovf_evt;
  logic [CW-1:0]         w_cnt_nxt;

  // Circular pointer increment; wraps at OBUF_DEPTH so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Occupancy includes the read still in flight, so the queue can never be overrun.
  assign w_occ     = {1'b0, r_cnt} + {{CW{1'b0}}, r_rd_pend};
  assign w_rd_en   = ~rrst & drain_en & ~fifo_rempty & (w_occ < DEPTH_EXT);
  assign w_rd_fire = w_rd_en & ~fifo_rempty;

  assign w_valid   = ~rrst & (r_cnt != '0);
  assign w_pop     = w_valid & out_ready;
  assign w_push    = r_rd_pend & ~rrst;
  assign w_full    = (r_cnt == CNT_FULL);
  assign w_wr_ok   = w_push & (~w_full | w_pop);
  assign w_ovf_evt = w_push & ~w_pop & w_full;

  // Next occupancy: push and pop in the same cycle leave the count unchanged.
  always_comb begin
    // NOTE: default assignment first so every path drives w_cnt_nxt and no latch is inferred.
    w_cnt_nxt = r_cnt;
    case ({w_wr_ok, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + CW'(1);
      2'b01:   w_cnt_nxt = r_cnt - CW'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Read-pending flag: marks that fifo_data_read carries a word on the next edge.
  always_ff @(posedge rclk) begin
    // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
    if (rrst) r_rd_pend <= 1'b0;
    else      r_rd_pend <= w_rd_fire;
  end

  // Queue pointers and occupancy.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)   r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_cnt <= w_cnt_nxt;
    end
  end

  // Queue storage: captures the FIFO word one cycle after the accepted read.
  always_ff @(posedge rclk) begin
    // NOTE: storage is deliberately not reset; r_cnt alone decides which entries are live.
    if (w_wr_ok) r_mem[r_wr_ptr] <= fifo_data_read;
  end

  // Packet framing beat counter and delivered-word counter, both advanced per pop.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_beat     <= '0;
      r_word_cnt <= '0;
    end else if (w_pop) begin
      r_beat     <= (r_beat == BEAT_LAST) ? '0 : r_beat + BW'(1);
      r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
    end
  end

  // Sticky overflow flag: a capture into a full queue without a simultaneous pop.
  always_ff @(posedge rclk) begin
    if (rrst)           r_ovf <= 1'b0;
    else if (w_ovf_evt) r_ovf <= 1'b1;
  end

  assign fifo_read_enable = w_rd_en;
  assign out_valid        = w_valid;
  assign out_data         = w_valid ? r_mem[r_rd_ptr] : '0;
  assign out_last         = w_valid & (r_beat == BEAT_LAST);
  assign word_cnt         = r_word_cnt;
  assign obuf_ovf         = r_ovf;

  // The issue rule reserves space for every in-flight read, so this must never fire.
  a_no_obuf_overflow: assert property (@(posedge rclk) disable iff (rrst) !w_ovf_evt);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: a queue-based FIFO model feeds the DUT and records the
// order of words read; every handshake is scored against that order and the packet
// position implied by the number of words delivered.
module tb_fifo_rd_stream;

  localparam int DW    = 9;
  localparam int DEPTH = 3;
  localparam int PKT   = 8;
  localparam int CW    = 16;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          drain_en;
  logic          fifo_rempty;
  logic [DW-1:0] fifo_data_read;
  logic          fifo_read_enable;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [CW-1:0] word_cnt;
  logic          obuf_ovf;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(
    .DATA_WIDTH(DW), .OBUF_DEPTH(DEPTH), .PKT_LEN(PKT), .CNT_WIDTH(CW)
  ) dut (
    .rclk             (rclk),
    .rrst             (rrst),
    .drain_en         (drain_en),
    .fifo_rempty      (fifo_rempty),
    .fifo_data_read   (fifo_data_read),
    .fifo_read_enable (fifo_read_enable),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_last         (out_last),
    .word_cnt         (word_cnt),
    .obuf_ovf         (obuf_ovf)
  );

  int n_chk = 0;
  int n_bad = 0;

  logic [DW-1:0] src_q[$];   // words still held by the modelled FIFO
  logic [DW-1:0] exp_q[$];   // words read from the FIFO and not yet delivered
  bit            inflight;   // a read fired on the most recent edge
  int            reads_total = 0;
  int            delivered   = 0;
  int            cyc         = 0;
  int            gap_pct     = 0;
  int            ready_pct   = 0;
  int            t_first_rd, t_first_vld, t_first_hs, t_last_hs, first_last_idx;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int            r0, d0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // FIFO model: registered data_read one cycle after an accepted read.
  always @(posedge rclk) begin
    if (rrst) begin
      exp_q.delete();
      inflight       <= 1'b0;
      fifo_data_read <= '0;
    end else begin
      inflight <= 1'b0;
      if (fifo_read_enable && !fifo_rempty && src_q.size() > 0) begin
        fifo_data_read <= src_q[0];
        exp_q.push_back(src_q.pop_front());
        inflight <= 1'b1;
        reads_total++;
      end
    end
  end

  task automatic clear_marks();
    t_first_rd = -1; t_first_vld = -1; t_first_hs = -1; t_last_hs = -1;
  endtask

  // One cycle: drive inputs just after a falling edge, observe, then wait for the next one.
  task automatic step();
    fifo_rempty = (src_q.size() == 0) || (int'($urandom_range(99)) < gap_pct);
    if (ready_pct >= 100)    out_ready = 1'b1;
    else if (ready_pct <= 0) out_ready = 1'b0;
    else                     out_ready = (int'($urandom_range(99)) < ready_pct);
    #1;
    if (rrst) begin
      check("rst_valid", 32'(out_valid), 0);
      check("rst_rden",  32'(fifo_read_enable), 0);
      check("rst_last",  32'(out_last), 0);
      check("rst_data",  32'(out_data), 0);
      prev_stall = 1'b0;
    end else begin
      check("rden_while_empty", 32'(fifo_read_enable & fifo_rempty), 0);
      check("outstanding_le_depth", 32'(exp_q.size() <= DEPTH), 1);
      check("valid", 32'(out_valid), 32'(exp_q.size() > int'(inflight)));
      check("word_cnt", 32'(word_cnt), 32'(delivered[CW-1:0]));
      check("ovf", 32'(obuf_ovf), 0);
      if (prev_stall) begin
        check("stall_data", 32'(out_data), 32'(prev_data));
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (fifo_read_enable && !fifo_rempty && t_first_rd < 0) t_first_rd = cyc;
      if (out_valid && t_first_vld < 0) t_first_vld = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("handshake_without_word", 1, 0);
        end else begin
          check("data", 32'(out_data), 32'(exp_q[0]));
          check("last", 32'(out_last), 32'((delivered % PKT) == PKT - 1));
          if (out_last && first_last_idx < 0) first_last_idx = delivered;
          void'(exp_q.pop_front());
        end
        delivered++;
        if (t_first_hs < 0) t_first_hs = cyc;
        t_last_hs = cyc;
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
    @(negedge rclk);
    cyc++;
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (delivered < target && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(delivered >= target), 1);
  endtask

  initial begin
    rrst = 1'b1; drain_en = 1'b0; out_ready = 1'b0; fifo_rempty = 1'b1;
    first_last_idx = -1; prev_stall = 1'b0;
    clear_marks();
    repeat (2) step();
    rrst = 1'b0;

    // 1: idle after reset with an empty FIFO.
    drain_en = 1'b1; ready_pct = 100;
    repeat (5) step();
    check("t1_rden", 32'(fifo_read_enable), 0);
    check("t1_valid", 32'(out_valid), 0);
    check("t1_word_cnt", 32'(word_cnt), 0);

    // 2: 20 words at full rate; framing checked per handshake.
    for (int i = 0; i < 20; i++) src_q.push_back(DW'(i));
    clear_marks();
    run_until(20, 200, "t2_timeout");
    check("t2_latency", 32'(t_first_vld - t_first_rd), 2);
    check("t2_burst_span", 32'(t_last_hs - t_first_hs), 19);
    step();
    check("t2_word_cnt", 32'(word_cnt), 20);

    // 3: stalled output: exactly DEPTH reads, then release.
    ready_pct = 0; r0 = reads_total; d0 = delivered;
    for (int i = 0; i < 10; i++) src_q.push_back(DW'(i));
    repeat (10) step();
    check("t3_reads", 32'(reads_total - r0), DEPTH);
    check("t3_rden_held", 32'(fifo_read_enable), 0);
    check("t3_valid", 32'(out_valid), 1);
    ready_pct = 100;
    run_until(d0 + 10, 100, "t3_timeout");
    check("t3_ovf", 32'(obuf_ovf), 0);

    // 4: random back-pressure and FIFO empty gaps.
    gap_pct = 30; ready_pct = 50; d0 = delivered;
    for (int i = 0; i < 1000; i++) src_q.push_back(DW'($urandom_range(511)));
    run_until(d0 + 1000, 20000, "t4_timeout");
    gap_pct = 0;
    check("t4_ovf", 32'(obuf_ovf), 0);

    // 5: drain_en dropped right after a read fires.
    drain_en = 1'b0; ready_pct = 100;
    repeat (3) step();
    for (int i = 0; i < 5; i++) src_q.push_back(DW'(9'h1A0 + i));
    r0 = reads_total; d0 = delivered;
    drain_en = 1'b1;
    step();
    drain_en = 1'b0;
    repeat (8) step();
    check("t5_reads_paused", 32'(reads_total - r0), 1);
    check("t5_inflight_delivered", 32'(delivered - d0), 1);
    check("t5_rden_off", 32'(fifo_read_enable), 0);
    drain_en = 1'b1;
    run_until(d0 + 5, 100, "t5_timeout");
    check("t5_reads_total", 32'(reads_total - r0), 5);

    // 6: reset with two queued words and one read in flight.
    drain_en = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 10; i++) src_q.push_back(DW'(9'h0F0 + i));
    ready_pct = 0; drain_en = 1'b1; r0 = reads_total;
    repeat (3) step();
    check("t6_pre_reads", 32'(reads_total - r0), 3);
    check("t6_pre_valid", 32'(out_valid), 1);
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    delivered = 0;
    src_q.delete();
    #1;
    check("t6_valid", 32'(out_valid), 0);
    check("t6_word_cnt", 32'(word_cnt), 0);
    check("t6_last", 32'(out_last), 0);
    for (int i = 0; i < 16; i++) src_q.push_back(DW'(9'h100 + i));
    first_last_idx = -1; ready_pct = 50;
    run_until(16, 500, "t6_timeout");
    check("t6_first_last_idx", 32'(first_last_idx), 7);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
